// File: rtl/instr_fetch_packer_pkg.sv
// Shared definitions for the nibble-serial instruction fetch/pack front end:
// opcode encodings, register index width, decoded instruction fields, FSM states.
package instr_fetch_packer_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_END = 4'd4;

  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  // The pc width depends on the top-level ADDR_W, so the top wraps this with its pc.
  typedef struct packed {
    logic [3:0] op;
    reg_idx_t   rd;
    reg_idx_t   rs1;
    reg_idx_t   rs2;
  } instr_fields_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_OP,
    S_F_RD,
    S_F_RS1,
    S_F_RS2,
    S_HALT
  } state_t;

  function automatic logic is_reg_nibble(input logic [3:0] nibble);
    return !nibble[3];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; push and pop may coincide at any
// occupancy, including full. Callers never push when full without popping.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // NOTE: storage is deliberately not reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_packer.sv
// Walks nibble-wide program memory, packs opcode/Rd/Rs1/Rs2 into one decoded
// word and queues it for the downstream stage; halts on END or illegal nibbles.
module instr_fetch_packer
  import instr_fetch_packer_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 2,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [3:0]        imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rs1,
  output logic [REG_W-1:0]  out_rs2,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  typedef struct packed {
    instr_fields_t     f;
    logic [ADDR_W-1:0] pc;
  } instr_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d, pc_q, pc_d;
  logic [3:0]        op_q, op_d;
  reg_idx_t          rd_q, rd_d, rs1_q, rs1_d;
  logic              err_q, set_err;
  logic              push, pop, fifo_full, fifo_empty;
  instr_t            push_word, head;

  assign pop = out_valid && out_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = imem_addr;
    pc_d    = pc_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    push    = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_F_OP;
        addr_d  = START;
      end
      S_F_OP: begin
        if (imem_data == OP_END) begin
          state_d = S_HALT;
        end else if (imem_data > OP_END) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end else begin
          op_d    = imem_data;
          pc_d    = imem_addr;
          addr_d  = imem_addr + 1'b1;
          state_d = S_F_RD;
        end
      end
      S_F_RD, S_F_RS1: begin
        if (!is_reg_nibble(imem_data)) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end else begin
          if (state_q == S_F_RD) rd_d = imem_data[REG_W-1:0];
          else                   rs1_d = imem_data[REG_W-1:0];
          addr_d  = imem_addr + 1'b1;
          state_d = (state_q == S_F_RD) ? S_F_RS1 : S_F_RS2;
        end
      end
      S_F_RS2: begin
        if (!is_reg_nibble(imem_data)) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end else if (!fifo_full || pop) begin
          push    = 1'b1;
          addr_d  = imem_addr + 1'b1;
          state_d = S_F_OP;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      imem_addr <= START;
      pc_q      <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      imem_addr <= addr_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      err_q     <= err_q | set_err;
    end
  end

  // Rs2 is taken straight from the memory so the push lands in the Rs2 cycle.
  assign push_word = '{f: '{op: op_q, rd: rd_q, rs1: rs1_q, rs2: imem_data[REG_W-1:0]}, pc: pc_q};

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(instr_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_op      = out_valid ? head.f.op  : '0;
  assign out_rd      = out_valid ? head.f.rd  : '0;
  assign out_rs1     = out_valid ? head.f.rs1 : '0;
  assign out_rs2     = out_valid ? head.f.rs2 : '0;
  assign out_pc      = out_valid ? head.pc    : '0;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign err_illegal = err_q;

endmodule
